dm_ctrl: RTL and testbench



---
 rtl/dm_pkg.sv | 45 ++++
 rtl/dm_load_align.sv | 21 ++
 rtl/dm_ctrl.sv | 132 +++++++++++++
 tb/tb_dm_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings, request payload and legality helpers for the data memory controller.
package dm_pkg;

   localparam int unsigned SIZE_W = 2;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
   localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
   localparam logic [SIZE_W-1:0] SZ_W = 2'd2;
   localparam logic [SIZE_W-1:0] SZ_R = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } dm_state_e;

   // Request fields captured at the accept edge (address kept separately: it is parametrised).
   typedef struct packed {
      logic              we;
      logic [SIZE_W-1:0] size;
      logic              sign_ext;
      logic [DATA_W-1:0] din;
   } dm_req_t;

   // Halfwords need even addresses, words need 4-byte alignment.
   function automatic logic is_misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] a);
      logic mis;
      mis = 1'b0;
      case (size)
         SZ_H:    mis = a[0];
         SZ_W:    mis = (a != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // A request is rejected if its size is reserved or its address is misaligned.
   function automatic logic is_illegal(input logic [SIZE_W-1:0] size, input logic [1:0] a);
      return (size == SZ_R) || is_misaligned(size, a);
   endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load path: picks the addressed bytes and applies sign or zero extension.
module dm_load_align
   import dm_pkg::*;
(
   input  logic [DATA_W-1:0] raw,
   input  logic [SIZE_W-1:0] size,
   input  logic              sign_ext,
   output logic [DATA_W-1:0] data_c
);

   // raw holds mem[a+3..a] little-endian; narrow loads use only the low lanes.
   always_comb begin
      data_c = raw;
      case (size)
         SZ_B:    data_c = {{24{sign_ext & raw[7]}}, raw[7:0]};
         SZ_H:    data_c = {{16{sign_ext & raw[15]}}, raw[15:0]};
         default: data_c = raw;
      endcase
   end

endmodule

// File: rtl/dm_ctrl.sv
// Byte-addressable little-endian data memory with req/ready handshake and wait states.
module dm_ctrl
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       din,
   output logic              ready,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       dout
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   dm_state_e         state;
   logic [CNT_W-1:0]  cnt;
   dm_req_t           lat;
   logic [ADDR_W-1:0] lat_addr;

   // Storage has no reset; it only changes through committed stores.
   logic [7:0]        mem [DEPTH];

   logic [ADDR_W-1:0] a1_c;
   logic [ADDR_W-1:0] a2_c;
   logic [ADDR_W-1:0] a3_c;
   logic [31:0]       raw_c;
   logic [31:0]       load_c;
   logic              last_c;
   logic              store_c;

   // Byte lane addresses of the latched access; aligned accesses never wrap.
   assign a1_c = lat_addr + ADDR_W'(1);
   assign a2_c = lat_addr + ADDR_W'(2);
   assign a3_c = lat_addr + ADDR_W'(3);

   assign raw_c   = {mem[a3_c], mem[a2_c], mem[a1_c], mem[lat_addr]};
   assign last_c  = (state == ST_BUSY) && (cnt == '0);
   assign store_c = last_c && lat.we;

   dm_load_align u_load_align (
      .raw      (raw_c),
      .size     (lat.size),
      .sign_ext (lat.sign_ext),
      .data_c   (load_c)
   );

   // Access sequencer: accept, wait out the busy count, then emit one response pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         lat        <= '0;
         lat_addr   <= '0;
         ready      <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         dout       <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  lat.we       <= we;
                  lat.size     <= size;
                  lat.sign_ext <= sign_ext;
                  lat.din      <= din;
                  lat_addr     <= addr;
                  ready        <= 1'b0;
                  if (is_illegal(size, addr[1:0])) begin
                     state <= ST_ERR;
                  end else begin
                     state <= ST_BUSY;
                     cnt   <= CNT_W'(WAIT_CYCLES);
                  end
               end
            end
            ST_BUSY: begin
               if (last_c) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  if (!lat.we) begin
                     dout <= load_c;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            // Rejected access: one dead cycle so the error response lands with the same latency.
            ST_ERR: begin
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b1;
               dout       <= '0;
            end
            ST_RESP: begin
               state <= ST_IDLE;
               ready <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   // Store commit on the edge entering the response cycle; only addressed lanes change.
   always_ff @(posedge clk) begin
      if (store_c) begin
         mem[lat_addr] <= lat.din[7:0];
         if (lat.size != SZ_B) begin
            mem[a1_c] <= lat.din[15:8];
         end
         if (lat.size == SZ_W) begin
            mem[a2_c] <= lat.din[23:16];
            mem[a3_c] <= lat.din[31:24];
         end
      end
   end

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: two instances (0 and 3 wait states) checked each cycle against a behavioural model.
module tb_dm_ctrl;
   import dm_pkg::*;

   localparam int unsigned AW = 10;
   localparam int unsigned NB = 1024;

   logic        clk = 1'b0;
   logic        rst_n [2];
   logic        req   [2];
   logic        we    [2];
   logic [1:0]  size  [2];
   logic        sext  [2];
   logic [AW-1:0] addr [2];
   logic [31:0] din   [2];
   logic        ready [2];
   logic        rv    [2];
   logic        rerr  [2];
   logic [31:0] dout  [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dm_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .size(size[0]),
      .sign_ext(sext[0]), .addr(addr[0]), .din(din[0]), .ready(ready[0]),
      .resp_valid(rv[0]), .resp_err(rerr[0]), .dout(dout[0]));

   dm_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .size(size[1]),
      .sign_ext(sext[1]), .addr(addr[1]), .din(din[1]), .ready(ready[1]),
      .resp_valid(rv[1]), .resp_err(rerr[1]), .dout(dout[1]));

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[dut%0d] t=%0t: got %h expected %h", nm, i, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Cycle n is the interval after clock edge n. An access accepted at edge T answers in cycle
   // T+lat-1 (lat = 2, or 2+wait for legal ones); ready is low from cycle T through the answer.
   logic [7:0]  mm [2][NB];
   int          ecnt = 0;
   bit          act  [2];
   int          pend [2];
   bit          p_err[2];
   bit          p_we [2];
   bit          p_sx [2];
   int          p_sz [2];
   int          p_a  [2];
   logic [31:0] p_d  [2];
   logic [31:0] m_dout [2];

   function automatic int lat_of(input int i, input bit e);
      return e ? 2 : 2 + ((i == 0) ? 0 : 3);
   endfunction

   function automatic bit illegal(input int sz, input int a);
      return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] mload(input int i, input int a, input int sz, input bit sx);
      int n;
      longint v;
      n = 1 << sz;
      v = 0;
      for (int k = 0; k < n; k++) v = v | (longint'(mm[i][a+k]) << (8*k));
      if (sx && v[8*n-1]) v = v | ((-64'sd1) << (8*n));
      return v[31:0];
   endfunction

   always @(posedge clk) begin
      ecnt++;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n[i]) begin
            act[i]    = 1'b0;
            m_dout[i] = '0;
         end else begin
            if (act[i] && ecnt == pend[i]) begin
               if (p_err[i])     m_dout[i] = '0;
               else if (p_we[i]) for (int k = 0; k < (1 << p_sz[i]); k++) mm[i][p_a[i]+k] = p_d[i][8*k +: 8];
               else              m_dout[i] = mload(i, p_a[i], p_sz[i], p_sx[i]);
            end
            if (req[i] && !(act[i] && (ecnt - 1) <= pend[i])) begin
               act[i]   = 1'b1;
               p_err[i] = illegal(int'(size[i]), int'(addr[i]));
               p_we[i]  = we[i];
               p_sx[i]  = sext[i];
               p_sz[i]  = int'(size[i]);
               p_a[i]   = int'(addr[i]);
               p_d[i]   = din[i];
               pend[i]  = ecnt + lat_of(i, p_err[i]) - 1;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit busy, xrv;
         busy = act[i] && (ecnt <= pend[i]);
         xrv  = act[i] && (ecnt == pend[i]);
         chk("ready", i, 32'(ready[i]), 32'(!busy));
         chk("resp_valid", i, 32'(rv[i]), 32'(xrv));
         chk("resp_err", i, 32'(rerr[i]), 32'(xrv && p_err[i]));
         chk("dout", i, dout[i], m_dout[i]);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_idle(input int i);
      int n = 0;
      @(negedge clk); #1;
      while (!ready[i] && n < 50) begin @(negedge clk); #1; n++; end
      chk("idle_wait", i, 32'(ready[i]), 32'd1);
   endtask

   task automatic access(input int i, input bit w, input logic [1:0] sz, input bit sx, input int a,
                         input logic [31:0] d, output logic [31:0] q, output logic e, output int l);
      wait_idle(i);
      req[i] = 1'b1; we[i] = w; size[i] = sz; sext[i] = sx; addr[i] = AW'(a); din[i] = d;
      @(posedge clk);
      @(negedge clk); #1;
      req[i] = 1'b0;
      l = 1;
      while (!rv[i] && l < 50) begin @(negedge clk); #1; l++; end
      q = dout[i];
      e = rerr[i];
   endtask

   task automatic op(input string nm, input int i, input bit w, input logic [1:0] sz, input bit sx,
                     input int a, input logic [31:0] d, input int xl, input bit xe, input bit cq,
                     input logic [31:0] xq);
      logic [31:0] q;
      logic        e;
      int          l;
      access(i, w, sz, sx, a, d, q, e, l);
      chk({nm, "_lat"}, i, 32'(l), 32'(xl));
      chk({nm, "_err"}, i, 32'(e), 32'(xe));
      if (cq) chk({nm, "_dout"}, i, q, xq);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] bexp [4];
      int rvc, first, rlow, r, sz, a;
      bexp = '{8'h21, 8'h43, 8'h65, 8'h87};
      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; size[i] = 2'd0;
         sext[i] = 1'b0; addr[i] = '0; din[i] = '0; act[i] = 1'b0; pend[i] = 0; m_dout[i] = '0;
         for (int k = 0; k < NB; k++) mm[i][k] = 8'h00;
      end

      repeat (2) @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready", i, 32'(ready[i]), 32'd1);
         chk("rst_rv", i, 32'(rv[i]), 32'd0);
         chk("rst_dout", i, dout[i], 32'd0);
         rst_n[i] = 1'b1;
      end

      // zero wait states: functional corner cases with literal expectations
      op("st_w",    0, 1, SZ_W, 0, 'h010, 32'h8765_4321, 2, 0, 0, 32'h0);
      op("ld_w",    0, 0, SZ_W, 0, 'h010, 32'h0, 2, 0, 1, 32'h8765_4321);
      for (int k = 0; k < 4; k++) op("ld_b_lane", 0, 0, SZ_B, 0, 'h010 + k, 32'h0, 2, 0, 1, {24'h0, bexp[k]});
      op("ld_b_sx", 0, 0, SZ_B, 1, 'h013, 32'h0, 2, 0, 1, 32'hFFFF_FF87);
      op("ld_b_zx", 0, 0, SZ_B, 0, 'h013, 32'h0, 2, 0, 1, 32'h0000_0087);
      op("ld_h_sx", 0, 0, SZ_H, 1, 'h012, 32'h0, 2, 0, 1, 32'hFFFF_8765);
      op("st_b",    0, 1, SZ_B, 0, 'h011, 32'h0000_00AA, 2, 0, 0, 32'h0);
      op("ld_w_b",  0, 0, SZ_W, 0, 'h010, 32'h0, 2, 0, 1, 32'h8765_AA21);
      op("st_h",    0, 1, SZ_H, 0, 'h012, 32'h0000_BEEF, 2, 0, 0, 32'h0);
      op("ld_w_h",  0, 0, SZ_W, 0, 'h010, 32'h0, 2, 0, 1, 32'hBEEF_AA21);
      op("err_ldw", 0, 0, SZ_W, 0, 'h002, 32'h0, 2, 1, 1, 32'h0);
      op("err_sth", 0, 1, SZ_H, 0, 'h005, 32'h0000_1111, 2, 1, 1, 32'h0);
      op("err_sz3", 0, 1, 2'd3, 0, 'h000, 32'h2222_2222, 2, 1, 1, 32'h0);
      op("ld_w4",   0, 0, SZ_W, 0, 'h004, 32'h0, 2, 0, 1, 32'h0);
      op("ld_w0",   0, 0, SZ_W, 0, 'h000, 32'h0, 2, 0, 1, 32'h0);

      // three wait states
      op("w3_st",   1, 1, SZ_W, 0, 'h040, 32'hCAFE_F00D, 5, 0, 0, 32'h0);
      op("w3_ld",   1, 0, SZ_W, 0, 'h040, 32'h0, 5, 0, 1, 32'hCAFE_F00D);

      // req held high through the busy period is taken only once
      wait_idle(1);
      req[1] = 1'b1; we[1] = 1'b0; size[1] = SZ_W; sext[1] = 1'b0; addr[1] = AW'(32'h40);
      @(posedge clk);
      rvc = 0; first = 0; rlow = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk); #1;
         if (rv[1]) begin rvc++; if (first == 0) first = k; end
         if (!ready[1]) rlow++;
         if (k == 5) req[1] = 1'b0;
      end
      chk("held_resp_count", 1, 32'(rvc), 32'd1);
      chk("held_resp_cycle", 1, 32'(first), 32'd5);
      chk("held_ready_low", 1, 32'(rlow), 32'd5);

      // reset during busy aborts the store
      wait_idle(1);
      req[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_W; addr[1] = AW'(32'h20); din[1] = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk); #1;
      req[1] = 1'b0;
      @(negedge clk); #1;
      rst_n[1] = 1'b0;
      #1;
      chk("abort_ready", 1, 32'(ready[1]), 32'd1);
      chk("abort_rv", 1, 32'(rv[1]), 32'd0);
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst_n[1] = 1'b1;
      op("abort_ld", 1, 0, SZ_W, 0, 'h020, 32'h0, 5, 0, 1, 32'h0);

      // randomized traffic on both instances, with occasional resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) rst_n[i] = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n[i] = 1'b0;
            r  = int'($urandom_range(0, 15));
            sz = (r == 15) ? 3 : (r % 3);
            a  = ($urandom_range(0, 3) == 0) ? (32'h3C0 + int'($urandom_range(0, 63))) : int'($urandom_range(0, 127));
            if (sz < 3 && $urandom_range(0, 7) != 0) a = a & ~((1 << sz) - 1);
            req[i]  = ($urandom_range(0, 2) != 0);
            we[i]   = 1'($urandom_range(0, 1));
            sext[i] = 1'($urandom_range(0, 1));
            size[i] = 2'(sz);
            addr[i] = AW'(a);
            din[i]  = $urandom;
         end
      end
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++) begin req[i] = 1'b0; rst_n[i] = 1'b1; end
      repeat (12) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
